// File: rtl/mem_trace_streamer.sv
// mem_trace_streamer: buffers core store events as {addr, data} records in a
// circular FIFO and streams them to a consumer over a valid/ready handshake.
// Stores are optionally filtered (zero addr/data), a full FIFO raises stall_req,
// and stores captured while full with no pop are counted in a saturating counter.
module mem_trace_streamer #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 48,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SKIP_ZERO = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_W+DATA_W-1:0]    out_rec,
  output logic                        stall_req,
  output logic [$clog2(DEPTH):0]      level,
  output logic [CNT_W-1:0]            drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned REC_W = ADDR_W + DATA_W;

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_valid;
  logic             r_full;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_cap;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [LVL_W-1:0] w_level_nxt;

  // Handshake events; flush cancels both push and drop in its cycle.
  always_comb begin
    w_cap  = wr_en & ((SKIP_ZERO == 0) | ((wr_addr != '0) & (wr_data != '0)));
    w_pop  = r_valid & out_ready;
    w_push = w_cap & (~r_full | w_pop) & ~flush;
    w_drop = w_cap & r_full & ~w_pop & ~flush;
  end

  // Next pointer and level values; flush returns everything to the empty state.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_level_nxt  = r_level;
    if (flush) begin
      w_rd_ptr_nxt = '0;
      w_wr_ptr_nxt = '0;
      w_level_nxt  = '0;
    end else begin
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      if (w_push && !w_pop)      w_level_nxt = r_level + LVL_W'(1);
      else if (w_pop && !w_push) w_level_nxt = r_level - LVL_W'(1);
    end
  end

  // Pointer, level and status flags; valid/full are registered copies of the level decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_level  <= w_level_nxt;
      r_valid  <= (w_level_nxt != '0);
      r_full   <= (w_level_nxt == LVL_W'(DEPTH));
    end
  end

  // Saturating count of records lost to a full FIFO; flush leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  // Record storage; contents survive reset since only pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {wr_addr, wr_data};
  end

  assign out_valid = r_valid;
  assign stall_req = r_full;
  assign level     = r_level;
  assign drop_cnt  = r_drop_cnt;
  assign out_rec   = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_mem_trace_streamer.sv
// Scoreboard bench for mem_trace_streamer: one filtering and one non-filtering
// instance share stimulus; monitors pop expected records as outputs transfer.
module tb_mem_trace_streamer;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [47:0] wr_data;
  logic        flush;
  logic        out_ready;

  logic        v1, v0;
  logic [63:0] rec1, rec0;
  logic        st1, st0;
  logic [3:0]  lvl1, lvl0;
  logic [15:0] dc1, dc0;

  logic [63:0] q1[$];
  logic [63:0] q0[$];

  int total = 0;
  int bad   = 0;

  mem_trace_streamer #(.ADDR_W(16), .DATA_W(48), .DEPTH(8), .SKIP_ZERO(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush), .out_valid(v1), .out_ready(out_ready), .out_rec(rec1),
    .stall_req(st1), .level(lvl1), .drop_cnt(dc1));

  mem_trace_streamer #(.ADDR_W(16), .DATA_W(48), .DEPTH(8), .SKIP_ZERO(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush), .out_valid(v0), .out_ready(out_ready), .out_rec(rec0),
    .stall_req(st0), .level(lvl0), .drop_cnt(dc0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [15:0] a, input logic [47:0] d);
    return {a, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [47:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Expected record for both instances.
  task automatic exp_both(input logic [15:0] a, input logic [47:0] d);
    q1.push_back(mk(a, d));
    q0.push_back(mk(a, d));
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (lvl1 == 4'd0 && lvl0 == 4'd0) break;
      tick();
    end
    chk("drain_level1", 64'(lvl1), 64'd0);
    chk("drain_level0", 64'(lvl0), 64'd0);
  endtask

  // Monitors: compare each transferred record against the head of its queue.
  always @(negedge clk) begin
    if (reset && v1 && out_ready) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected_rec got=%h want=none", rec1);
      end else begin
        chk("dut1_rec", rec1, q1.pop_front());
      end
    end
    if (reset && v0 && out_ready) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_unexpected_rec got=%h want=none", rec0);
      end else begin
        chk("dut0_rec", rec0, q0.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_valid", 64'(v1), 64'd0);
    chk("rst_stall", 64'(st1), 64'd0);
    chk("rst_level", 64'(lvl1), 64'd0);
    chk("rst_drop", 64'(dc1), 64'd0);
    #21 reset = 1'b1;
    tick();

    // Single store, 1-cycle latency, then empty again.
    out_ready = 1'b1;
    exp_both(16'h0010, 48'h1234);
    store(16'h0010, 48'h1234);
    chk("t1_valid", 64'(v1), 64'd1);
    chk("t1_rec", rec1, 64'h0010_0000_0000_1234);
    tick();
    chk("t1_valid_after", 64'(v1), 64'd0);
    chk("t1_level_after", 64'(lvl1), 64'd0);

    // Zero filtering: filtered instance keeps only the fully non-zero store.
    q0.push_back(mk(16'h0000, 48'h55));
    q0.push_back(mk(16'h0020, 48'h0));
    exp_both(16'h0030, 48'h7);
    store(16'h0000, 48'h55);
    store(16'h0020, 48'h0);
    store(16'h0030, 48'h7);
    tick(); tick();
    chk("t2_drop1", 64'(dc1), 64'd0);
    chk("t2_drop0", 64'(dc0), 64'd0);
    drain();

    // Overflow: 10 stores into 8 entries with consumer stalled.
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8) exp_both(16'h0100, 48'(k));
      store(16'h0100, 48'(k));
      if (k == 7) chk("t3_stall_at7", 64'(st1), 64'd0);
      if (k == 8) begin
        chk("t3_stall_at8", 64'(st1), 64'd1);
        chk("t3_level_at8", 64'(lvl1), 64'd8);
      end
    end
    chk("t3_drop1", 64'(dc1), 64'd2);
    chk("t3_drop0", 64'(dc0), 64'd2);
    chk("t3_level", 64'(lvl1), 64'd8);
    out_ready = 1'b1;
    drain();

    // Full FIFO with push and pop every cycle.
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      exp_both(16'h0200, 48'(16'h0200 + k));
      store(16'h0200, 48'(16'h0200 + k));
    end
    chk("t4_full_level", 64'(lvl1), 64'd8);
    out_ready = 1'b1;
    for (int k = 9; k <= 28; k++) begin
      exp_both(16'h0200, 48'(16'h0200 + k));
      store(16'h0200, 48'(16'h0200 + k));
      chk("t4_level", 64'(lvl1), 64'd8);
    end
    chk("t4_drop", 64'(dc1), 64'd2);
    drain();

    // Flush with a simultaneous store.
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) store(16'h0300, 48'(16'h0300 + k));
    chk("t5_level_pre", 64'(lvl1), 64'd5);
    flush = 1'b1;
    store(16'h0300, 48'h306);
    flush = 1'b0;
    chk("t5_level", 64'(lvl1), 64'd0);
    chk("t5_valid", 64'(v1), 64'd0);
    chk("t5_drop", 64'(dc1), 64'd2);
    out_ready = 1'b1;
    exp_both(16'h0300, 48'h307);
    store(16'h0300, 48'h307);
    chk("t5_rec", rec1, 64'h0300_0000_0000_0307);
    drain();

    // Asynchronous reset mid-stream while full and stalled.
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) store(16'h0400, 48'(16'h0400 + k));
    chk("t6_valid_pre", 64'(v1), 64'd1);
    chk("t6_stall_pre", 64'(st1), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid", 64'(v1), 64'd0);
    chk("t6_stall", 64'(st1), 64'd0);
    chk("t6_level", 64'(lvl1), 64'd0);
    chk("t6_drop", 64'(dc1), 64'd0);
    chk("t6_drop0", 64'(dc0), 64'd0);
    #3 reset = 1'b1;
    tick();
    out_ready = 1'b1;
    exp_both(16'h0500, 48'h500);
    store(16'h0500, 48'h500);
    chk("t6_post_valid", 64'(v1), 64'd1);
    chk("t6_post_rec", rec1, 64'h0500_0000_0000_0500);
    tick();
    chk("t6_post_level", 64'(lvl1), 64'd0);

    tick(); tick();
    chk("q1_empty", 64'(q1.size()), 64'd0);
    chk("q0_empty", 64'(q0.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_trace_streamer.md
# mem_trace_streamer

- Buffers data-memory store events from the vector processor core as {address, data} records and streams them to a consumer over a valid/ready handshake.
- Successor to the single-cycle combinational `data`/`enable` output tap:
  - parametrised widths and depth;
  - records are not lost when the consumer stalls;
  - optional zero-record filtering;
  - back-pressure to the core;
  - a drop counter.
- Sits between the core's store port and the text-dump / host link logic.

## Interface

Parameters:
- ADDR_W, 16, store address width.
- DATA_W, 48, store data width.
- DEPTH, 8, FIFO entries; power of two, ≥ 2.
- SKIP_ZERO, 1, when 1 a store is captured only if addr ≠ 0 and data ≠ 0; when 0 every store is captured.
- CNT_W, 16, drop counter width.

Ports:
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, asynchronous, active-low reset; clears all state immediately on assertion.
- wr_en, in, 1, core store strobe (memWrite of the memory stage).
- wr_addr, in, ADDR_W, store address.
- wr_data, in, DATA_W, store data.
- flush, in, 1, synchronous clear of buffered records.
- out_valid, out, 1, head record is valid.
- out_ready, in, 1, consumer accepts the head record.
- out_rec, out, ADDR_W+DATA_W, head record as {addr, data}, addr in the MSBs.
- stall_req, out, 1, FIFO full; the core should hold its store.
- level, out, $clog2(DEPTH)+1, number of buffered records.
- drop_cnt, out, CNT_W, saturating count of captured-but-dropped records.

## Operation

- Capture condition `cap` = wr_en & (SKIP_ZERO == 0 | (wr_addr ≠ 0 & wr_data ≠ 0)).
- `pop` = out_valid & out_ready.
- `push` = cap & (!full | pop) & !flush.
- Storage:
  - circular buffer with read pointer and write pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - level counter 0..DEPTH;
  - full = (level == DEPTH), empty = (level == 0).
- Per-edge level update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with simultaneous pop: the push is accepted and level stays at DEPTH.
- Full without pop: the record is dropped.
  - drop_cnt increments by 1 and saturates at 2^CNT_W − 1.
  - Pointers are unchanged.
- Empty: pop is impossible because out_valid = 0. A push into an empty FIFO has no bypass; the record appears on the next cycle.
- Flush (has priority over everything except reset):
  - read pointer, write pointer and level go to 0;
  - the pop and push of that cycle are discarded and not counted as drops;
  - drop_cnt is retained.
- out_rec is driven from the entry at the read pointer. Its value is don't-care while out_valid = 0, but must be stable while out_valid = 1 and out_ready = 0.
- Ordering: strictly FIFO. No record is duplicated or reordered.
- Reset (asynchronous, any time including mid-transfer): pointers, level, drop_cnt = 0; out_valid = 0; stall_req = 0. Storage contents are not cleared.

## Timing

- Capture at edge N → out_valid = 1 and out_rec = record from cycle N+1. Minimum latency is 1 cycle.
- out_valid = !empty, derived from registered state only; it has no combinational path from any input.
- stall_req = full, derived from registered state only.
  - The core samples it in the same cycle.
  - One store issued while stall_req = 1 with no pop is dropped and counted; the core is responsible for not issuing it.
- Handshake: a record transfers on each edge where out_valid = 1 and out_ready = 1.
  - Throughput is 1 record/cycle sustained, with simultaneous push and pop at any level.
- level and drop_cnt are registered and update on the same edge as the causing event.
- Reset outputs: out_valid 0, stall_req 0, level 0, drop_cnt 0, out_rec undefined.

## Test plan

- Reset, then store (0x0010, 0x1234) with out_ready = 1.
  - Expect out_valid = 1 the next cycle with out_rec = {0x0010, 0x000000001234}.
  - Then out_valid = 0 and level = 0.
- SKIP_ZERO = 1: stores (0x0000, 0x55), (0x0020, 0x0), (0x0030, 0x7).
  - Expect only {0x0030, 0x7} emitted and drop_cnt = 0.
  - Repeat with SKIP_ZERO = 0: expect all 3 emitted in order.
- out_ready = 0, 10 consecutive stores of data 1..10 at DEPTH = 8.
  - Expect stall_req = 1 after the 8th store, drop_cnt = 2, level = 8.
  - Then release out_ready: expect data 1..8 in order and no 9 or 10.
- Full FIFO, simultaneous store and out_ready = 1 each cycle for 20 cycles.
  - Expect level stays 8, no drops, and the output sequence is contiguous.
- 5 records buffered, flush pulsed together with a store.
  - Expect level = 0 and out_valid = 0 next cycle, drop_cnt unchanged, and the flushed-cycle store absent.
- Assert reset low mid-stream while out_valid = 1 and out_ready = 0.
  - Expect out_valid, stall_req, level and drop_cnt to go to 0 immediately, without waiting for clk.
  - After release, the next store is emitted after 1 cycle.
